// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes WIDTH-bit operands DIGIT bits per clock
// through one reused ripple slice, with start/done handshake and signed overflow.
//
// state  | meaning
// IDLE   | waiting for start, last result held
// RUN    | one slice per edge, counter 0..N-1
// DONE   | result valid, done pulse; start here chains the next op
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             car_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             car_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;
  logic [WIDTH-1:0] res_next;

  always_comb begin : slice_add
    logic c;
    c          = carry;
    slice_sum  = '0;
    slice_cmsb = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) slice_cmsb = c;
      slice_sum[i] = a_sh[i] ^ b_sh[i] ^ c;
      c = (a_sh[i] & b_sh[i]) | (c & (a_sh[i] ^ b_sh[i]));
    end
    slice_cout = c;
    // New digit enters at the top; after N slices the LSB digit sits at bit 0.
    res_next = WIDTH'({slice_sum, res_sh} >> DIGIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      car_out  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : car_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          carry  <= slice_cout;
          res_sh <= res_next;
          if (cnt == CW'(N - 1)) begin
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum      <= res_next;
            car_out  <= slice_cout;
            overflow <= slice_cmsb ^ slice_cout;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder: 16/4 instance for directed and
// random ops, plus 8-bit instances with DIGIT=1,2,8 checked against an arithmetic model.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 16-bit, DIGIT=4
  logic        start16, sub16, cin16;
  logic [15:0] a16, b16;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .car_in(cin16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .sum(sum16),
    .car_out(cout16), .overflow(ovf16)
  );

  // 8-bit sweep, shared stimulus
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy_d1, done_d1, cout_d1, ovf_d1;
  logic       busy_d2, done_d2, cout_d2, ovf_d2;
  logic       busy_d8, done_d8, cout_d8, ovf_d8;
  logic [7:0] sum_d1, sum_d2, sum_d8;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .car_in(cin8),
    .a(a8), .b(b8), .busy(busy_d1), .done(done_d1), .sum(sum_d1),
    .car_out(cout_d1), .overflow(ovf_d1)
  );
  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .car_in(cin8),
    .a(a8), .b(b8), .busy(busy_d2), .done(done_d2), .sum(sum_d2),
    .car_out(cout_d2), .overflow(ovf_d2)
  );
  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .car_in(cin8),
    .a(a8), .b(b8), .busy(busy_d8), .done(done_d8), .sum(sum_d8),
    .car_out(cout_d8), .overflow(ovf_d8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/carry, signed range for overflow.
  task automatic model(input int w, input longint av, input longint bv, input bit s,
                       input bit ci, output longint es, output bit ec, output bit eo);
    longint m, u, sa, sb, r, lo, hi;
    m  = (longint'(1) << w) - 1;
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    sa = (av > hi) ? av - (m + 1) : av;
    sb = (bv > hi) ? bv - (m + 1) : bv;
    if (s) begin
      u  = av - bv;
      ec = (av >= bv);
      r  = sa - sb;
    end else begin
      u  = av + bv + longint'(ci);
      ec = (u > m);
      r  = sa + sb + longint'(ci);
    end
    es = u & m;
    eo = (r > hi) || (r < lo);
  endtask

  task automatic wait_done16(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done16) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_result16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                                input bit s, input bit ci);
    longint es; bit ec, eo;
    model(16, longint'(av), longint'(bv), s, ci, es, ec, eo);
    check({tag, ".sum"}, 32'(sum16), 32'(es));
    check({tag, ".cout"}, 32'(cout16), 32'(ec));
    check({tag, ".ovf"}, 32'(ovf16), 32'(eo));
  endtask

  // Full op with latency, busy and single-cycle done checks; inputs scrambled after accept.
  task automatic op16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                      input bit s, input bit ci);
    int lat;
    bit busy_ok;
    a16 = av; b16 = bv; sub16 = s; cin16 = ci; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom); cin16 = 1'($urandom);
    busy_ok = busy16 && !done16;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done16) begin
        lat = k;
        break;
      end
      busy_ok = busy_ok && busy16;
    end
    check({tag, ".lat"}, 32'(lat), 32'd4);
    check({tag, ".busy"}, 32'(busy_ok), 32'd1);
    check({tag, ".busy_at_done"}, 32'(busy16), 32'd0);
    check_result16(tag, av, bv, s, ci);
    tick();
    check({tag, ".done_pulse"}, 32'(done16), 32'd0);
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit s, input bit ci);
    int l1, l2, l8;
    longint es; bit ec, eo;
    a8 = av; b8 = bv; sub8 = s; cin8 = ci; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    l1 = -1; l2 = -1; l8 = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done_d1 && l1 < 0) l1 = k;
      if (done_d2 && l2 < 0) l2 = k;
      if (done_d8 && l8 < 0) l8 = k;
    end
    model(8, longint'(av), longint'(bv), s, ci, es, ec, eo);
    check("d1.lat", 32'(l1), 32'd8);
    check("d2.lat", 32'(l2), 32'd4);
    check("d8.lat", 32'(l8), 32'd1);
    check("d1.res", {21'd0, ovf_d1, cout_d1, 1'b0, sum_d1}, {21'd0, eo, ec, 1'b0, 8'(es)});
    check("d2.res", {21'd0, ovf_d2, cout_d2, 1'b0, sum_d2}, {21'd0, eo, ec, 1'b0, 8'(es)});
    check("d8.res", {21'd0, ovf_d8, cout_d8, 1'b0, sum_d8}, {21'd0, eo, ec, 1'b0, 8'(es)});
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    tick(); tick();
    check("rst.w16", {busy16, done16, cout16, ovf16, sum16}, 32'd0);
    check("rst.w8", {busy_d1, done_d1, busy_d2, done_d2, busy_d8, done_d8, sum_d1, sum_d2, sum_d8},
          32'd0);
    rst = 1'b0;
    tick();

    op16("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op16("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    op16("add_cin", 16'h1234, 16'h1111, 1'b0, 1'b1);
    op16("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1);
    op16("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1'b0);

    // start pulsed mid-run is ignored
    a16 = 16'h4000; b16 = 16'h4000; sub16 = 1'b0; cin16 = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick();
    a16 = 16'h0101; b16 = 16'h0202; sub16 = 1'b1; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    wait_done16(lat);
    check("ign.lat", 32'(lat), 32'd2);
    check_result16("ign", 16'h4000, 16'h4000, 1'b0, 1'b0);
    tick();

    // start held through DONE chains the next op, done spacing N+1
    a16 = 16'h00F0; b16 = 16'h000F; sub16 = 1'b0; cin16 = 1'b1; start16 = 1'b1;
    tick();
    a16 = 16'h9000; b16 = 16'h1000; sub16 = 1'b1; cin16 = 1'b0;
    wait_done16(lat);
    check("b2b.lat1", 32'(lat), 32'd4);
    check_result16("b2b1", 16'h00F0, 16'h000F, 1'b0, 1'b1);
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    check("b2b.busy", 32'(busy16), 32'd1);
    wait_done16(lat);
    check("b2b.gap", 32'(lat + 1), 32'd5);
    check_result16("b2b2", 16'h9000, 16'h1000, 1'b1, 1'b0);
    tick();

    // reset during slice 2 of a subtract, then a fresh add must not inherit carry
    a16 = 16'h0003; b16 = 16'h0001; sub16 = 1'b1; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst", {busy16, done16, cout16, ovf16, sum16}, 32'd0);
    tick();
    op16("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++)
      op16("rnd16", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    op8(8'h7F, 8'h01, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b1, 1'b1);
    op8(8'hFF, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
